apb4_cmd_master: RTL and testbench
==================================

Name: apb4_cmd_master

Overview:
- Stimulus-side bus master that sits directly upstream of the regblock test adapter's CPU interface.
- Accepts a stream of read/write commands over a valid/ready port and drives them as APB4 transfers onto the adapter's s_apb_* cpuif ports.
- Returns one response per command (read data plus error status) over a valid/ready response port.
- Decouples directed and random test sequences from APB protocol timing. Used in all APB4 cpuif regression benches.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and s_apb_paddr.
- DATA_WIDTH, 32, width of write/read data. Must be 8, 16, 32 or 64.
- CMD_DEPTH, 4, command FIFO depth. Power of two, >= 2.
- TIMEOUT_CYCLES, 64, maximum wait-state cycles before abort. Only used with the optional feature.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_error  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- s_apb_psel  out  1  APB select.
- s_apb_penable  out  1  APB enable.
- s_apb_pwrite  out  1  APB direction.
- s_apb_paddr  out  ADDR_WIDTH  APB address.
- s_apb_pwdata  out  DATA_WIDTH  APB write data.
- s_apb_pstrb  out  DATA_WIDTH/8  APB strobes; all zero for reads.
- s_apb_pprot  out  3  tied 3'b000.
- s_apb_pready  in  1  completer ready.
- s_apb_prdata  in  DATA_WIDTH  completer read data.
- s_apb_pslverr  in  1  completer error.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. While rst is high, all outputs are 0, the FIFO is empty and the FSM is in IDLE. Asserting rst mid-transfer abandons that transfer: psel drops on the next edge and no response is generated.
- Command FIFO:
  - cmd_ready = !full.
  - Push when cmd_valid && cmd_ready.
  - Pop only when the head transfer completes. A push while full is not possible because ready is low.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE -> SETUP when the FIFO is non-empty. Head fields are loaded into the APB output registers.
  - SETUP: psel=1, penable=0. Always moves to ACCESS after exactly one cycle.
  - ACCESS: psel=1, penable=1. Remains while pready=0. When pready=1: capture prdata (reads only, else 0) and pslverr, pop the FIFO, go to RESP.
  - RESP: psel=0, penable=0, rsp_valid=1. rsp_rdata, rsp_error and rsp_timeout are held stable until rsp_ready.
  - On the rsp handshake: go to SETUP if the FIFO is non-empty (loading the next head), else IDLE.
- APB outputs are registered. paddr, pwrite, pwdata and pstrb are stable from SETUP through ACCESS.
- Latency: push at edge E0 -> psel high after E1 -> penable high after E2. With zero wait states (pready=1 at E3), rsp_valid is high after E3. Each wait state adds one cycle.
- At most one outstanding APB transfer and one pending response. No new SETUP is issued while RESP is unacknowledged.

Optional Feature:
- Macro: APB4_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: pop the FIFO, go to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - If pready=1 arrives on the same cycle the count hits the limit, pready wins and the response is a normal completion.
- Undefined: ACCESS waits indefinitely, rsp_timeout is tied to 0, and no counter is instantiated.

Test Plan:
- Reset, then write addr 0x10, data 0xDEADBEEF, strb 0xF, pready=1 -> psel at +1, penable at +2 with paddr 0x10 and pwdata 0xDEADBEEF; rsp_valid at +3 with rdata 0, error 0.
- Read 0x04 with 3 wait states, completer returns 0x12345678 -> penable held 4 cycles; rsp_rdata 0x12345678, rsp_error 0.
- Push 5 commands with CMD_DEPTH=4 and rsp_ready=0 -> cmd_ready low after the 4th accepted push (FIFO still holds 4 while response 1 is pending). Raise rsp_ready=1 -> all 5 responses returned in order.
- Read with pslverr=1 at completion -> rsp_error=1, rsp_timeout=0, rsp_rdata equals prdata.
- With APB4_CMD_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, hold pready=0 -> after 8 ACCESS cycles psel=0, rsp_error=1, rsp_timeout=1. The next queued command then issues normally.
- Assert rst during ACCESS of a write -> psel/penable 0 on the next cycle, no rsp_valid, cmd_ready=1, FIFO empty.

Source files
------------

// File: rtl/apb4_cmd_master.sv
// APB4 command master: queued read/write commands become APB4 transfers, one response each (APB4_CMD_MASTER_TIMEOUT_EN adds a wait-state abort).
// Latency: push -> psel +1 cycle, penable +2, rsp_valid +3 with zero wait states; each wait state adds one cycle.
// Backpressure: cmd_ready drops when the FIFO is full; no new SETUP is issued until the pending response is taken.

module apb4_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + 1'b1;
         if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_vld, pop_vld})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module apb4_cmd_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_error,
   output logic                    rsp_timeout,
   output logic                    s_apb_psel,
   output logic                    s_apb_penable,
   output logic                    s_apb_pwrite,
   output logic [ADDR_WIDTH-1:0]   s_apb_paddr,
   output logic [DATA_WIDTH-1:0]   s_apb_pwdata,
   output logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
   output logic [2:0]              s_apb_pprot,
   input  logic                    s_apb_pready,
   input  logic [DATA_WIDTH-1:0]   s_apb_prdata,
   input  logic                    s_apb_pslverr
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $error("apb4_cmd_master: DATA_WIDTH must be 8, 16, 32 or 64");
   end
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("apb4_cmd_master: CMD_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb4_cmd_master: TIMEOUT_CYCLES must be >= 1");
   end

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state;
   state_t state_nxt;
   cmd_t   push_dat;
   cmd_t   head_dat;
   logic   full;
   logic   empty;
   logic   push_vld;
   logic   pop;
   logic   load;
   logic   capture;
   logic   abort;
   logic   to_hit;

   assign cmd_ready   = !full && !rst;
   assign push_vld    = cmd_valid && cmd_ready;
   assign push_dat    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
   assign s_apb_pprot = 3'b000;

   apb4_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_vld  (pop),
      .head_dat (head_dat),
      .full     (full),
      .empty    (empty)
   );

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            timeout_q;

   // Hitting the limit on this cycle means TIMEOUT_CYCLES stalled ACCESS cycles have elapsed.
   assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout = timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state != ACCESS)    to_cnt <= '0;
         else if (!s_apb_pready) to_cnt <= to_cnt + 1'b1;
         if (capture)    timeout_q <= 1'b0;
         else if (abort) timeout_q <= 1'b1;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_nxt = SETUP;
               load      = 1'b1;
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            // pready wins over a timeout landing on the same cycle.
            if (s_apb_pready) begin
               capture   = 1'b1;
               pop       = 1'b1;
               state_nxt = RESP;
            end else if (to_hit) begin
               abort     = 1'b1;
               pop       = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               if (!empty) begin
                  state_nxt = SETUP;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         s_apb_psel    <= 1'b0;
         s_apb_penable <= 1'b0;
         s_apb_pwrite  <= 1'b0;
         s_apb_paddr   <= '0;
         s_apb_pwdata  <= '0;
         s_apb_pstrb   <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
      end else begin
         state         <= state_nxt;
         s_apb_psel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         s_apb_penable <= (state_nxt == ACCESS);
         rsp_valid     <= (state_nxt == RESP);
         if (load) begin
            s_apb_pwrite <= head_dat.write;
            s_apb_paddr  <= head_dat.addr;
            s_apb_pwdata <= head_dat.wdata;
            s_apb_pstrb  <= head_dat.write ? head_dat.strb : '0;
         end
         if (capture) begin
            rsp_rdata <= s_apb_pwrite ? '0 : s_apb_prdata;
            rsp_error <= s_apb_pslverr;
         end else if (abort) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master: scoreboard queues of expected responses and APB transfers,
// checked by monitors on the falling edge against a small memory-backed APB completer.
module tb_apb4_cmd_master;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        rsp_timeout;
   logic        s_apb_psel;
   logic        s_apb_penable;
   logic        s_apb_pwrite;
   logic [31:0] s_apb_paddr;
   logic [31:0] s_apb_pwdata;
   logic [3:0]  s_apb_pstrb;
   logic [2:0]  s_apb_pprot;
   logic        s_apb_pready;
   logic [31:0] s_apb_prdata;
   logic        s_apb_pslverr;

   always #5 clk = ~clk;

   apb4_cmd_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .CMD_DEPTH      (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_strb      (cmd_strb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_error     (rsp_error),
      .rsp_timeout   (rsp_timeout),
      .s_apb_psel    (s_apb_psel),
      .s_apb_penable (s_apb_penable),
      .s_apb_pwrite  (s_apb_pwrite),
      .s_apb_paddr   (s_apb_paddr),
      .s_apb_pwdata  (s_apb_pwdata),
      .s_apb_pstrb   (s_apb_pstrb),
      .s_apb_pprot   (s_apb_pprot),
      .s_apb_pready  (s_apb_pready),
      .s_apb_prdata  (s_apb_prdata),
      .s_apb_pslverr (s_apb_pslverr)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [7:0]  acc;   // expected ACCESS cycles, 0 = don't care
   } apb_t;

   rsp_t exp_rsp_q[$];
   apb_t exp_apb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Completer: 16-word memory, configurable wait states, error region at paddr[11:8]==4'hE.
   logic [31:0] mem [16];
   int unsigned wait_states = 0;
   logic        hold = 1'b0;
   int unsigned acc_cnt = 0;

   assign s_apb_pready  = s_apb_psel && s_apb_penable && (acc_cnt >= wait_states) && !hold;
   assign s_apb_prdata  = mem[s_apb_paddr[5:2]];
   assign s_apb_pslverr = s_apb_pready && (s_apb_paddr[11:8] == 4'hE);

   always @(posedge clk) begin
      if (s_apb_psel && s_apb_penable && !s_apb_pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (s_apb_psel && s_apb_penable && s_apb_pready && s_apb_pwrite)
         for (int b = 0; b < 4; b++)
            if (s_apb_pstrb[b]) mem[s_apb_paddr[5:2]][8*b +: 8] <= s_apb_pwdata[8*b +: 8];
   end

   // APB monitor: checks each completed transfer against the expected queue.
   initial begin
      logic        setup_seen;
      logic [31:0] setup_addr;
      int          acc_len;
      apb_t        e;
      setup_seen = 1'b0;
      setup_addr = '0;
      acc_len    = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            setup_seen = 1'b0;
            acc_len    = 0;
         end else if (s_apb_psel && !s_apb_penable) begin
            setup_seen = 1'b1;
            setup_addr = s_apb_paddr;
            acc_len    = 0;
         end else if (s_apb_psel && s_apb_penable) begin
            acc_len++;
            if (s_apb_pready) begin
               if (exp_apb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL apb_unexpected: transfer at addr %h with no expectation", s_apb_paddr);
               end else begin
                  e = exp_apb_q.pop_front();
                  chk("apb_setup_phase", 64'(setup_seen), 64'd1);
                  chk("apb_addr_stable", 64'(s_apb_paddr), 64'(setup_addr));
                  chk("apb_pwrite", 64'(s_apb_pwrite), 64'(e.wr));
                  chk("apb_paddr", 64'(s_apb_paddr), 64'(e.addr));
                  chk("apb_pstrb", 64'(s_apb_pstrb), 64'(e.strb));
                  chk("apb_pprot", 64'(s_apb_pprot), 64'd0);
                  if (e.wr) chk("apb_pwdata", 64'(s_apb_pwdata), 64'(e.wdata));
                  if (e.acc != 0) chk("apb_access_cycles", 64'(acc_len), 64'(e.acc));
               end
               setup_seen = 1'b0;
            end
         end
      end
   end

   // Response monitor: in-order compare on handshake, plus hold-stability while stalled.
   initial begin
      logic prev_pend;
      rsp_t prev;
      rsp_t cur;
      rsp_t e;
      prev_pend = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         cur = '{rdata: rsp_rdata, err: rsp_error, tmo: rsp_timeout};
         if (rst) begin
            prev_pend = 1'b0;
         end else begin
            if (rsp_valid && prev_pend) chk("rsp_hold_stable", 64'(cur), 64'(prev));
            if (rsp_valid && rsp_ready) begin
               chk("rsp_no_overlap_psel", 64'(s_apb_psel), 64'd0);
               if (exp_rsp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: rdata %h err %b tmo %b", rsp_rdata, rsp_error, rsp_timeout);
               end else begin
                  e = exp_rsp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  chk("rsp_error", 64'(rsp_error), 64'(e.err));
                  chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
               end
            end
            prev_pend = rsp_valid && !rsp_ready;
            prev      = cur;
         end
      end
   end

   // trk[1]: expect a response, trk[0]: expect a completed APB transfer.
   task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] ex_rd, input logic ex_err,
                       input logic ex_tmo, input logic [7:0] ex_acc, input logic [1:0] trk);
      int n;
      if (trk[1]) exp_rsp_q.push_back('{rdata: ex_rd, err: ex_err, tmo: ex_tmo});
      if (trk[0]) exp_apb_q.push_back('{wr: wr, addr: addr, wdata: wd, strb: (wr ? st : 4'h0), acc: ex_acc});
      @(negedge clk);
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_strb  = st;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL push_accept: cmd_ready stayed %b for addr %h", cmd_ready, addr);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_rsp_q.size() != 0 || exp_apb_q.size() != 0 || s_apb_psel || rsp_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s: still busy, %0d responses and %0d transfers outstanding",
                  name, exp_rsp_q.size(), exp_apb_q.size());
      end
   endtask

   task automatic wait_penable(input string name);
      int n;
      n = 0;
      while (!s_apb_penable && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s: penable never rose, got %b required 1", name, s_apb_penable);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic seen_psel;
      logic seen_rsp;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[1] = 32'h1234_5678;
      mem[2] = 32'hA5A5_5A5A;
      mem[5] = 32'hFFFF_FFFF;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", 64'(s_apb_psel), 64'd0);
      chk("rst_penable", 64'(s_apb_penable), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_paddr", 64'(s_apb_paddr), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Zero-wait write with cycle-exact latency
      exp_rsp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
      exp_apb_q.push_back('{wr: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, strb: 4'hF, acc: 8'd1});
      cmd_write = 1'b1;
      cmd_addr  = 32'h10;
      cmd_wdata = 32'hDEAD_BEEF;
      cmd_strb  = 4'hF;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      chk("lat_psel_e0", 64'(s_apb_psel), 64'd0);
      @(posedge clk); #1;
      chk("lat_psel_e1", 64'(s_apb_psel), 64'd1);
      chk("lat_penable_e1", 64'(s_apb_penable), 64'd0);
      chk("lat_paddr_e1", 64'(s_apb_paddr), 64'h10);
      @(posedge clk); #1;
      chk("lat_penable_e2", 64'(s_apb_penable), 64'd1);
      chk("lat_pwdata_e2", 64'(s_apb_pwdata), 64'hDEAD_BEEF);
      @(posedge clk); #1;
      chk("lat_rsp_valid_e3", 64'(rsp_valid), 64'd1);
      chk("lat_psel_e3", 64'(s_apb_psel), 64'd0);
      wait_idle("idle_write");

      // Read with three wait states: penable held four cycles
      wait_states = 3;
      push(1'b0, 32'h04, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 8'd4, 2'b11);
      wait_idle("idle_wait_read");
      wait_states = 0;

      // Partial strobes, read-back, and write data retained in the completer
      push(1'b1, 32'h14, 32'h1122_3344, 4'h3, 32'h0, 1'b0, 1'b0, 8'd1, 2'b11);
      push(1'b0, 32'h14, 32'h0, 4'hF, 32'hFFFF_3344, 1'b0, 1'b0, 8'd1, 2'b11);
      push(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'd1, 2'b11);
      wait_idle("idle_strobe");

      // Slave error on a read: data still returned
      push(1'b0, 32'hE08, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b1, 1'b0, 8'd1, 2'b11);
      wait_idle("idle_slverr");

      // FIFO fill and response backpressure
      @(posedge clk);
      #1 begin rsp_ready = 1'b0; hold = 1'b1; end
      push(1'b1, 32'h20, 32'h0101_0101, 4'hF, 32'h0, 1'b0, 1'b0, 8'd0, 2'b11);
      push(1'b0, 32'h20, 32'h0, 4'h0, 32'h0101_0101, 1'b0, 1'b0, 8'd1, 2'b11);
      push(1'b1, 32'h24, 32'hCAFE_F00D, 4'hC, 32'h0, 1'b0, 1'b0, 8'd1, 2'b11);
      push(1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFE_0000, 1'b0, 1'b0, 8'd1, 2'b11);
      @(negedge clk);
      chk("fill_cmd_ready_4", 64'(cmd_ready), 64'd0);
      @(posedge clk);
      #1 hold = 1'b0;
      push(1'b0, 32'h04, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 8'd1, 2'b11);
      @(negedge clk);
      chk("fill_cmd_ready_5", 64'(cmd_ready), 64'd0);
      chk("fill_rsp_pending", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle("idle_fill");

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
      // Timeout abort, then the next queued command issues normally
      @(posedge clk);
      #1 hold = 1'b1;
      push(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 8'd0, 2'b10);
      push(1'b0, 32'h08, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 1'b0, 8'd1, 2'b11);
      wait_penable("tmo_penable");
      n = 0;
      while (s_apb_penable && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_access_cycles", 64'(n), 64'd8);
      chk("tmo_psel_dropped", 64'(s_apb_psel), 64'd0);
      chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1 hold = 1'b0;
      wait_idle("idle_timeout");
`endif

      // Reset during ACCESS of a write abandons it and flushes the FIFO
      @(posedge clk);
      #1 hold = 1'b1;
      push(1'b1, 32'h30, 32'h5555_5555, 4'hF, 32'h0, 1'b0, 1'b0, 8'd0, 2'b00);
      push(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 8'd0, 2'b00);
      wait_penable("rst_mid_penable");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_psel", 64'(s_apb_psel), 64'd0);
      chk("rst_mid_penable", 64'(s_apb_penable), 64'd0);
      chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      rst  = 1'b0;
      hold = 1'b0;
      seen_psel = 1'b0;
      seen_rsp  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_psel |= s_apb_psel;
         seen_rsp  |= rsp_valid;
      end
      chk("rst_fifo_empty_no_psel", 64'(seen_psel), 64'd0);
      chk("rst_no_rsp", 64'(seen_rsp), 64'd0);
      chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_write_not_done", 64'(mem[12]), 64'd0);
      push(1'b0, 32'h04, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 8'd1, 2'b11);
      wait_idle("idle_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
